// File: rtl/vga_fb_arbiter.sv
// Shares one single-port 9-bit framebuffer RAM between raster-order scanout prefetch and a pixel writer.
// Latency: frame_start -> first read next cycle -> pix_valid two cycles later (registered FIFO push).
// Backpressure: writer is held off (wr_ready=0) only while RUN and FIFO occupancy is below LOW_WATER.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int AW         = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_pop,
  output logic [8:0]    pix_data,
  output logic          pix_valid,
  output logic          underrun,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [8:0]    wr_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [8:0]    ram_wdata,
  input  logic [8:0]    ram_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW-1:0] LOW_OCC   = CW'(LOW_WATER);
  localparam logic [CW-1:0] FULL_OCC  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count, occ;
  logic [AW-1:0] rd_addr;
  logic          rd_inflight;
  logic [8:0]    hold_data;
  logic          rd_issue, push, pop;

  // Occupancy counts the read in flight so a full FIFO can never be overrun by returning data.
  assign occ       = fifo_count + CW'(rd_inflight);
  // A returning read that coincides with frame_start belongs to the old frame and is dropped.
  assign push      = rd_inflight && !frame_start;
  assign pop       = pix_pop && (fifo_count != '0) && !frame_start;
  assign pix_valid = (fifo_count != '0);
  // When empty, the last shown head is held so the VGA stage sees a stable value.
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : hold_data;
  assign ram_wdata = wr_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: frame_start always restarts; RUN ends once the last pixel's read issues.
  always_comb begin
    state_nxt = state;
    if (frame_start)                            state_nxt = RUN;
    else if (rd_issue && rd_addr == LAST_ADDR)  state_nxt = DONE;
  end

  // RAM slot arbitration: scanout below low water always wins, otherwise the writer does.
  always_comb begin
    rd_issue = 1'b0;
    wr_ready = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = wr_addr;
    if (state == RUN && !frame_start) begin
      if (occ < LOW_OCC)                        rd_issue = 1'b1;
      else if (occ < FULL_OCC && !wr_valid)     rd_issue = 1'b1;
    end
    if (!rst) begin
      if (rd_issue) begin
        ram_en   = 1'b1;
        ram_addr = rd_addr;
      end else begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
      end
    end
  end

  // Scanout address, in-flight flag, FIFO pointers/count, held pixel and sticky underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rd_addr     <= '0;
      rd_inflight <= 1'b0;
      hold_data   <= '0;
      underrun    <= 1'b0;
    end else if (frame_start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      rd_addr     <= '0;
      rd_inflight <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      if (rd_issue && rd_addr != LAST_ADDR) rd_addr <= rd_addr + AW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (pix_pop && fifo_count == '0) underrun <= 1'b1;
      if (fifo_count != '0) hold_data <= fifo_mem[rd_ptr];
    end
  end

  // FIFO storage: read data lands here the cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

endmodule
